// File: rtl/latch_mem_wb_skid.sv
//------------------------------------------------------------------------------
// Module      : latch_mem_wb_skid
// Description : MEM/WB pipeline register with valid/ready handshake and a
//               one-entry skid buffer, flush, bubble-safe write enable,
//               forwarding-hit compare and a retired-instruction counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module latch_mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [1:0]        WBackVector_i,
  input  logic [DATA_W-1:0] wbDato_i,
  input  logic [DATA_W-1:0] aluOut_i,
  input  logic [REG_AW-1:0] regDest_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              memToReg_o,
  output logic              regWrite_o,
  output logic [DATA_W-1:0] wbDato_o,
  output logic [DATA_W-1:0] aluOut_o,
  output logic [REG_AW-1:0] regDest_o,
  input  logic [REG_AW-1:0] fwdRs_i,
  input  logic [REG_AW-1:0] fwdRt_i,
  output logic              fwdRsHit_o,
  output logic              fwdRtHit_o,
  output logic [CNT_W-1:0]  retireCnt_o
);

  // Main entry (drives the outputs) and skid entry (one overflow item)
  logic              r_mainValid;
  logic              r_mainMemToReg;
  logic              r_mainRegWrite;
  logic [DATA_W-1:0] r_mainWbDato;
  logic [DATA_W-1:0] r_mainAluOut;
  logic [REG_AW-1:0] r_mainRegDest;

  logic              r_skidValid;
  logic              r_skidMemToReg;
  logic              r_skidRegWrite;
  logic [DATA_W-1:0] r_skidWbDato;
  logic [DATA_W-1:0] r_skidAluOut;
  logic [REG_AW-1:0] r_skidRegDest;

  logic [CNT_W-1:0]  r_retireCnt;

  logic w_inFire;
  logic w_outFire;
  logic w_loadMainFromIn;
  logic w_loadMainFromSkid;
  logic w_loadSkid;
  logic w_regWrite;

  // ready_o comes straight from the skid flop, so it is registered and has
  // no combinational path from ready_i back to the MEM stage.
  assign ready_o   = ~r_skidValid;
  assign w_inFire  = valid_i & ready_o;
  assign w_outFire = r_mainValid & ready_i;

  // Capture decisions; a flush suppresses every load so input is dropped.
  // Main takes the input when empty, or when draining with nothing in skid.
  assign w_loadMainFromIn   = ~flush_i & w_inFire &
                              (~r_mainValid | (w_outFire & ~r_skidValid));
  assign w_loadMainFromSkid = ~flush_i & w_outFire & r_skidValid;
  assign w_loadSkid         = ~flush_i & w_inFire & r_mainValid & ~w_outFire;

  // Valid bits for main and skid entries
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (flush_i) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else begin
      if (w_loadMainFromIn || w_loadMainFromSkid) begin
        r_mainValid <= 1'b1;
      end else if (w_outFire) begin
        r_mainValid <= 1'b0;
      end
      if (w_loadSkid) begin
        r_skidValid <= 1'b1;
      end else if (w_loadMainFromSkid) begin
        r_skidValid <= 1'b0;
      end
    end
  end

  // Main payload: loads only on capture, otherwise holds (stable under stall)
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_mainMemToReg <= 1'b0;
      r_mainRegWrite <= 1'b0;
      r_mainWbDato   <= '0;
      r_mainAluOut   <= '0;
      r_mainRegDest  <= '0;
    end else if (w_loadMainFromSkid) begin
      r_mainMemToReg <= r_skidMemToReg;
      r_mainRegWrite <= r_skidRegWrite;
      r_mainWbDato   <= r_skidWbDato;
      r_mainAluOut   <= r_skidAluOut;
      r_mainRegDest  <= r_skidRegDest;
    end else if (w_loadMainFromIn) begin
      r_mainMemToReg <= WBackVector_i[1];
      r_mainRegWrite <= WBackVector_i[0];
      r_mainWbDato   <= wbDato_i;
      r_mainAluOut   <= aluOut_i;
      r_mainRegDest  <= regDest_i;
    end
  end

  // Skid payload: loads only when main is stalled and a new item arrives
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_skidMemToReg <= 1'b0;
      r_skidRegWrite <= 1'b0;
      r_skidWbDato   <= '0;
      r_skidAluOut   <= '0;
      r_skidRegDest  <= '0;
    end else if (w_loadSkid) begin
      r_skidMemToReg <= WBackVector_i[1];
      r_skidRegWrite <= WBackVector_i[0];
      r_skidWbDato   <= wbDato_i;
      r_skidAluOut   <= aluOut_i;
      r_skidRegDest  <= regDest_i;
    end
  end

  // Retire counter: every WB consumption counts, flush included; wraps freely
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_retireCnt <= '0;
    end else if (w_outFire) begin
      r_retireCnt <= r_retireCnt + CNT_W'(1);
    end
  end

  // Write enable is gated by entry valid and held low while reset is asserted
  assign w_regWrite  = r_mainRegWrite & r_mainValid & ~RST_i;

  assign valid_o     = r_mainValid;
  assign memToReg_o  = r_mainMemToReg;
  assign regWrite_o  = w_regWrite;
  assign wbDato_o    = r_mainWbDato;
  assign aluOut_o    = r_mainAluOut;
  assign regDest_o   = r_mainRegDest;
  assign retireCnt_o = r_retireCnt;

  // Register 0 is hard-wired zero, so it never forwards
  assign fwdRsHit_o  = w_regWrite & (r_mainRegDest != '0) & (r_mainRegDest == fwdRs_i);
  assign fwdRtHit_o  = w_regWrite & (r_mainRegDest != '0) & (r_mainRegDest == fwdRt_i);

endmodule

`default_nettype wire

// File: tb/tb_latch_mem_wb_skid.sv
//------------------------------------------------------------------------------
// Module      : tb_latch_mem_wb_skid
// Description : Self-checking bench for latch_mem_wb_skid against a
//               two-deep FIFO reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_latch_mem_wb_skid;

  localparam int c_DW = 32;
  localparam int c_AW = 5;
  localparam int c_CW = 4;

  typedef struct packed {
    logic            memToReg;
    logic            regWrite;
    logic [c_DW-1:0] wbDato;
    logic [c_DW-1:0] aluOut;
    logic [c_AW-1:0] regDest;
  } item_t;

  logic            CLK_i = 1'b0;
  logic            RST_i;
  logic            valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [1:0]      WBackVector_i;
  logic [c_DW-1:0] wbDato_i, aluOut_i, wbDato_o, aluOut_o;
  logic [c_AW-1:0] regDest_i, regDest_o, fwdRs_i, fwdRt_i;
  logic            memToReg_o, regWrite_o, fwdRsHit_o, fwdRtHit_o;
  logic [c_CW-1:0] retireCnt_o;

  latch_mem_wb_skid #(.DATA_W(c_DW), .REG_AW(c_AW), .CNT_W(c_CW)) dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .WBackVector_i(WBackVector_i), .wbDato_i(wbDato_i),
    .aluOut_i(aluOut_i), .regDest_i(regDest_i), .valid_o(valid_o),
    .ready_i(ready_i), .memToReg_o(memToReg_o), .regWrite_o(regWrite_o),
    .wbDato_o(wbDato_o), .aluOut_o(aluOut_o), .regDest_o(regDest_o),
    .fwdRs_i(fwdRs_i), .fwdRt_i(fwdRt_i), .fwdRsHit_o(fwdRsHit_o),
    .fwdRtHit_o(fwdRtHit_o), .retireCnt_o(retireCnt_o)
  );

  always #5 CLK_i = ~CLK_i;

  // Reference model: the stage holds at most two items in arrival order
  item_t           q[$];
  logic [c_CW-1:0] cntModel;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t rndItem(input logic [c_AW-1:0] dest);
    item_t it;
    it.memToReg = 1'($urandom);
    it.regWrite = 1'($urandom);
    it.wbDato   = $urandom;
    it.aluOut   = $urandom;
    it.regDest  = dest;
    return it;
  endfunction

  // Compare every output against the model at mid-cycle
  task automatic checkOutputs();
    logic  expValid, expWe;
    item_t h;
    expValid = (q.size() > 0);
    h        = expValid ? q[0] : '0;
    expWe    = expValid & h.regWrite;
    chk("ready_o", 64'(ready_o), 64'(q.size() < 2));
    chk("valid_o", 64'(valid_o), 64'(expValid));
    chk("regWrite_o", 64'(regWrite_o), 64'(expWe));
    chk("fwdRsHit_o", 64'(fwdRsHit_o), 64'(expWe && h.regDest != 0 && h.regDest == fwdRs_i));
    chk("fwdRtHit_o", 64'(fwdRtHit_o), 64'(expWe && h.regDest != 0 && h.regDest == fwdRt_i));
    chk("retireCnt_o", 64'(retireCnt_o), 64'(cntModel));
    if (expValid) begin
      chk("memToReg_o", 64'(memToReg_o), 64'(h.memToReg));
      chk("wbDato_o", 64'(wbDato_o), 64'(h.wbDato));
      chk("aluOut_o", 64'(aluOut_o), 64'(h.aluOut));
      chk("regDest_o", 64'(regDest_o), 64'(h.regDest));
    end
  endtask

  // One clock: drive inputs at negedge, check, then advance the model at posedge
  task automatic step(input bit v, input bit rdy, input bit fl, input item_t it,
                      input logic [c_AW-1:0] rs, input logic [c_AW-1:0] rt);
    bit inFire, outFire;
    valid_i       = v;
    ready_i       = rdy;
    flush_i       = fl;
    WBackVector_i = {it.memToReg, it.regWrite};
    wbDato_i      = it.wbDato;
    aluOut_i      = it.aluOut;
    regDest_i     = it.regDest;
    fwdRs_i       = rs;
    fwdRt_i       = rt;
    #1;
    checkOutputs();
    inFire  = v && (q.size() < 2);
    outFire = rdy && (q.size() > 0);
    @(posedge CLK_i);
    if (outFire) begin
      void'(q.pop_front());
      cntModel = cntModel + 1'b1;
    end
    if (fl) q.delete();
    else if (inFire) q.push_back(it);
    @(negedge CLK_i);
  endtask

  task automatic doReset();
    RST_i = 1'b1;
    #1;
    chk("rst valid_o", 64'(valid_o), 64'd0);
    chk("rst regWrite_o", 64'(regWrite_o), 64'd0);
    chk("rst ready_o", 64'(ready_o), 64'd1);
    chk("rst retireCnt_o", 64'(retireCnt_o), 64'd0);
    q.delete();
    cntModel = '0;
    @(negedge CLK_i);
    RST_i = 1'b0;
  endtask

  initial begin
    item_t it;
    RST_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    WBackVector_i = '0; wbDato_i = '0; aluOut_i = '0; regDest_i = '0;
    fwdRs_i = '0; fwdRt_i = '0;
    cntModel = '0;
    @(negedge CLK_i);
    doReset();

    // Streaming: eight back-to-back items, one-cycle latency
    for (int i = 1; i <= 8; i++) step(1, 1, 0, rndItem(c_AW'(i)), c_AW'(i - 1), 0);
    step(0, 1, 0, '0, 0, 0);
    step(0, 1, 0, '0, 0, 0);
    chk("stream count", 64'(retireCnt_o), 64'd8);

    // Back-pressure: A then B while WB stalls, then drain in order
    step(1, 0, 0, rndItem(5'd10), 0, 0);
    step(1, 0, 0, rndItem(5'd11), 0, 0);
    step(1, 0, 0, rndItem(5'd12), 0, 0);
    chk("bp ready_o low", 64'(ready_o), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 0, 0);

    // Flush with skid full and a live input on the same cycle
    step(1, 0, 0, rndItem(5'd20), 0, 0);
    step(1, 0, 0, rndItem(5'd21), 0, 0);
    step(1, 0, 1, rndItem(5'd22), 0, 0);
    chk("flush valid_o", 64'(valid_o), 64'd0);
    chk("flush ready_o", 64'(ready_o), 64'd1);
    step(0, 0, 0, '0, 0, 0);

    // Forwarding: regDest 5 hits, regDest 0 never hits, empty stage never hits
    it = rndItem(5'd5); it.regWrite = 1'b1;
    step(1, 0, 0, it, 0, 0);
    step(0, 0, 0, '0, 5'd5, 5'd5);
    chk("fwd hit rs5", 64'(fwdRsHit_o), 64'd1);
    step(0, 1, 0, '0, 5'd5, 5'd4);
    it = rndItem(5'd0); it.regWrite = 1'b1;
    step(1, 0, 0, it, 0, 0);
    step(0, 1, 0, '0, 5'd0, 5'd0);
    step(0, 0, 0, '0, 5'd5, 5'd0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
           rndItem(c_AW'($urandom)), c_AW'($urandom_range(0, 3)), c_AW'($urandom));
    end

    // Reset mid-burst, without an edge
    step(1, 0, 0, rndItem(5'd7), 0, 0);
    step(1, 0, 0, rndItem(5'd8), 0, 0);
    #2;
    doReset();

    // Counter wrap: 17 retirements on a 4-bit counter
    for (int i = 0; i < 17; i++) step(1, 1, 0, rndItem(c_AW'(i)), 0, 0);
    step(0, 1, 0, '0, 0, 0);
    chk("wrap count", 64'(retireCnt_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
